// File: rtl/mvm_addr_seq.sv
// Matrix-vector read-address sequencer: walks vector/matrix SRAM addresses row by row,
// with stall backpressure, a latency-matched accumulator flag delay line and a drain/done phase.
module mvm_addr_seq #(
  parameter int unsigned VEC_ADDRW = 8,
  parameter int unsigned MAT_ADDRW = 9,
  parameter int unsigned VEC_SIZEW = VEC_ADDRW + 1,
  parameter int unsigned MAT_SIZEW = MAT_ADDRW + 1,
  parameter int unsigned PIPE_LAT  = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [VEC_ADDRW-1:0] vec_start_addr,
  input  logic [VEC_SIZEW-1:0] vec_num_words,
  input  logic [MAT_ADDRW-1:0] mat_start_addr,
  input  logic [MAT_SIZEW-1:0] mat_num_rows,
  input  logic [MAT_SIZEW-1:0] mat_row_stride,
  input  logic                 stall,
  output logic [VEC_ADDRW-1:0] vec_raddr,
  output logic [MAT_ADDRW-1:0] mat_raddr,
  output logic                 ovalid,
  output logic                 accum_valid,
  output logic                 accum_first,
  output logic                 accum_last,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  localparam int unsigned CNTW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DRAIN} state_t;

  state_t r_state, w_state_nxt;

  logic [VEC_ADDRW-1:0] r_vec_start;
  logic [VEC_SIZEW-1:0] r_num_words;
  logic [MAT_SIZEW-1:0] r_num_rows;
  logic [MAT_SIZEW-1:0] r_stride;
  logic [VEC_SIZEW-1:0] r_word_cnt;
  logic [MAT_SIZEW-1:0] r_row_cnt;
  logic [MAT_ADDRW-1:0] r_row_base;
  logic [CNTW-1:0]      r_drain_cnt;

  logic [VEC_ADDRW-1:0] r_vec_raddr;
  logic [MAT_ADDRW-1:0] r_mat_raddr;
  logic                 r_ovalid, r_first, r_last;
  logic                 r_busy, r_done, r_cfg_err;

  logic [PIPE_LAT-1:0]  r_dl_v, r_dl_f, r_dl_l;

  logic w_word_last, w_row_last;
  logic w_accept, w_reject, w_issue, w_drain_end;

  assign w_word_last = (r_word_cnt == r_num_words - VEC_SIZEW'(1));
  assign w_row_last  = (r_row_cnt  == r_num_rows  - MAT_SIZEW'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_issue     = 1'b0;
    w_drain_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (vec_num_words == '0 || mat_num_rows == '0) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_COMPUTE;
          end
        end
      end
      S_COMPUTE: begin
        if (!stall) begin
          w_issue = 1'b1;
          if (w_word_last && w_row_last) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == CNTW'(PIPE_LAT - 1)) begin
          w_drain_end = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec_start <= '0;
      r_num_words <= '0;
      r_num_rows  <= '0;
      r_stride    <= '0;
      r_word_cnt  <= '0;
      r_row_cnt   <= '0;
      r_row_base  <= '0;
      r_drain_cnt <= '0;
      r_vec_raddr <= '0;
      r_mat_raddr <= '0;
      r_ovalid    <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= w_reject;
      r_done    <= w_drain_end;
      // Still in DRAIN on the final edge, so busy covers the done cycle.
      r_busy    <= (r_state != S_IDLE) || w_accept;
      r_ovalid  <= w_issue;
      r_first   <= w_issue && (r_word_cnt == '0);
      r_last    <= w_issue && w_word_last;

      if (w_accept) begin
        r_vec_start <= vec_start_addr;
        r_num_words <= vec_num_words;
        r_num_rows  <= mat_num_rows;
        r_stride    <= mat_row_stride;
        r_word_cnt  <= '0;
        r_row_cnt   <= '0;
        r_row_base  <= mat_start_addr;
      end

      if (w_issue) begin
        r_vec_raddr <= r_vec_start + VEC_ADDRW'(r_word_cnt);
        r_mat_raddr <= r_row_base + MAT_ADDRW'(r_word_cnt);
        if (w_word_last) begin
          r_word_cnt <= '0;
          r_row_cnt  <= r_row_cnt + MAT_SIZEW'(1);
          r_row_base <= r_row_base + MAT_ADDRW'(r_stride);
        end else begin
          r_word_cnt <= r_word_cnt + VEC_SIZEW'(1);
        end
      end

      if (r_state != S_DRAIN) r_drain_cnt <= '0;
      else                    r_drain_cnt <= r_drain_cnt + CNTW'(1);
    end
  end

  // Shifts every cycle, independent of stall, so flags keep fixed latency to ovalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dl_v <= '0;
      r_dl_f <= '0;
      r_dl_l <= '0;
    end else begin
      r_dl_v[0] <= r_ovalid;
      r_dl_f[0] <= r_first;
      r_dl_l[0] <= r_last;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        r_dl_v[i] <= r_dl_v[i-1];
        r_dl_f[i] <= r_dl_f[i-1];
        r_dl_l[i] <= r_dl_l[i-1];
      end
    end
  end

  assign vec_raddr   = r_vec_raddr;
  assign mat_raddr   = r_mat_raddr;
  assign ovalid      = r_ovalid;
  assign accum_valid = r_dl_v[PIPE_LAT-1];
  assign accum_first = r_dl_v[PIPE_LAT-1] & r_dl_f[PIPE_LAT-1];
  assign accum_last  = r_dl_v[PIPE_LAT-1] & r_dl_l[PIPE_LAT-1];
  assign busy        = r_busy;
  assign done        = r_done;
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_mvm_addr_seq.sv
// Directed self-checking bench for mvm_addr_seq: addressing, stall, wrap, config errors,
// back-to-back start and mid-run reset.
module tb_mvm_addr_seq;

  localparam int P = 7;

  logic       clk = 1'b0;
  logic       rst, start, stall;
  logic [7:0] vec_start_addr;
  logic [8:0] vec_num_words;
  logic [8:0] mat_start_addr;
  logic [9:0] mat_num_rows;
  logic [9:0] mat_row_stride;
  logic [7:0] vec_raddr;
  logic [8:0] mat_raddr;
  logic       ovalid, accum_valid, accum_first, accum_last, busy, done, cfg_err;

  int n_checks = 0;
  int n_errors = 0;
  int cur_t    = 0;

  bit          exp_ov [64];
  bit          exp_av [64];
  bit          exp_af [64];
  bit          exp_al [64];
  logic [31:0] exp_vec[64];
  logic [31:0] exp_mat[64];

  always #5 clk = ~clk;

  mvm_addr_seq #(
    .VEC_ADDRW(8),
    .MAT_ADDRW(9),
    .VEC_SIZEW(9),
    .MAT_SIZEW(10),
    .PIPE_LAT (P)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .vec_start_addr(vec_start_addr),
    .vec_num_words (vec_num_words),
    .mat_start_addr(mat_start_addr),
    .mat_num_rows  (mat_num_rows),
    .mat_row_stride(mat_row_stride),
    .stall         (stall),
    .vec_raddr     (vec_raddr),
    .mat_raddr     (mat_raddr),
    .ovalid        (ovalid),
    .accum_valid   (accum_valid),
    .accum_first   (accum_first),
    .accum_last    (accum_last),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d: got 0x%0h expected 0x%0h", tag, cur_t, got, exp);
    end
  endtask

  task automatic set_cfg(input int vs, input int n, input int ms, input int r, input int s);
    vec_start_addr = 8'(vs);
    vec_num_words  = 9'(n);
    mat_start_addr = 9'(ms);
    mat_num_rows   = 10'(r);
    mat_row_stride = 10'(s);
  endtask

  // Expects start already driven in the current cycle. Stall is held for sl cycles
  // right after the sa-th issue is seen. With chain=1, start is re-asserted in the done cycle.
  task automatic run_job(input int n, input int r, input int s, input int vs, input int ms,
                         input int sa, input int sl, input bit chain);
    int total, tw, t_done, t_end;
    total = n * r;
    for (int i = 0; i < 64; i++) begin
      exp_ov[i] = 0; exp_av[i] = 0; exp_af[i] = 0; exp_al[i] = 0;
      exp_vec[i] = 0; exp_mat[i] = 0;
    end
    tw = 0;
    for (int w = 0; w < total; w++) begin
      tw = w + 2 + ((sl > 0 && w >= sa) ? sl : 0);
      exp_ov[tw]     = 1;
      exp_vec[tw]    = 32'((vs + w % n) % 256);
      exp_mat[tw]    = 32'((ms + (w / n) * s + w % n) % 512);
      exp_av[tw + P] = 1;
      exp_af[tw + P] = (w % n == 0);
      exp_al[tw + P] = (w % n == n - 1);
    end
    t_done = tw + P;
    for (int t = 3; t < 64; t++) begin
      if (!exp_ov[t]) begin
        exp_vec[t] = exp_vec[t-1];
        exp_mat[t] = exp_mat[t-1];
      end
    end
    t_end = chain ? t_done : t_done + 2;
    for (int t = 1; t <= t_end; t++) begin
      @(negedge clk);
      cur_t = t;
      if (t == 1) start = 1'b0;
      check("ovalid", 32'(ovalid), 32'(exp_ov[t]));
      if (t >= 2) begin
        check("vec_raddr", 32'(vec_raddr), exp_vec[t]);
        check("mat_raddr", 32'(mat_raddr), exp_mat[t]);
      end
      check("accum_valid", 32'(accum_valid), 32'(exp_av[t]));
      check("accum_first", 32'(accum_first), 32'(exp_af[t]));
      check("accum_last",  32'(accum_last),  32'(exp_al[t]));
      check("done", 32'(done), 32'(t == t_done));
      check("busy", 32'(busy), 32'(t <= t_done));
      check("cfg_err", 32'(cfg_err), 32'(0));
      stall = (sl > 0 && t > sa && t <= sa + sl);
      if (chain && t == t_done) start = 1'b1;
    end
    stall = 1'b0;
  endtask

  task automatic cfg_reject(input int n, input int r);
    set_cfg(8'h10, n, 9'h20, r, 4);
    start = 1'b1;
    @(negedge clk);
    cur_t = 1;
    start = 1'b0;
    check("cfg_err_pulse", 32'(cfg_err), 32'(1));
    check("cfg_err_busy", 32'(busy), 32'(0));
    @(negedge clk);
    cur_t = 2;
    check("cfg_err_clear", 32'({cfg_err, busy, ovalid, done}), 32'(0));
    repeat (3) @(negedge clk);
    cur_t = 5;
    check("cfg_err_idle", 32'({cfg_err, busy, ovalid, accum_valid, done}), 32'(0));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({vec_raddr, mat_raddr, ovalid, accum_valid, accum_first,
                                accum_last, busy, done, cfg_err}), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // N=4 R=3 S=4, no stall
    set_cfg(8'h10, 4, 9'h20, 3, 4);
    start = 1'b1;
    run_job(4, 3, 4, 8'h10, 9'h20, 0, 0, 1'b0);

    // same with a 3-cycle stall after the 5th issue
    set_cfg(8'h10, 4, 9'h20, 3, 4);
    start = 1'b1;
    run_job(4, 3, 4, 8'h10, 9'h20, 5, 3, 1'b0);

    // matrix address wrap
    set_cfg(0, 2, 9'h1FC, 2, 8);
    start = 1'b1;
    run_job(2, 2, 8, 0, 9'h1FC, 0, 0, 1'b0);

    cfg_reject(0, 3);
    cfg_reject(4, 0);

    // N=1 R=5, then back-to-back start in the done cycle
    set_cfg(3, 1, 9'h40, 5, 1);
    start = 1'b1;
    run_job(1, 5, 1, 3, 9'h40, 0, 0, 1'b1);
    set_cfg(8'h20, 2, 9'h100, 2, 3);
    run_job(2, 2, 3, 8'h20, 9'h100, 0, 0, 1'b0);

    // reset after the 3rd issue of an N=4 R=2 run
    set_cfg(0, 4, 0, 2, 4);
    start = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      cur_t = t;
      if (t == 1) start = 1'b0;
    end
    check("rst_mid_ovalid", 32'(ovalid), 32'(1));
    check("rst_mid_vec", 32'(vec_raddr), 32'(2));
    rst = 1'b1;
    @(negedge clk);
    cur_t = 5;
    rst = 1'b0;
    check("rst_mid_outputs", 32'({vec_raddr, mat_raddr, ovalid, accum_valid, accum_first,
                                  accum_last, busy, done, cfg_err}), 32'(0));
    for (int t = 6; t < 26; t++) begin
      @(negedge clk);
      cur_t = t;
      check("post_rst_quiet", 32'({ovalid, accum_valid, busy, done}), 32'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mvm_addr_seq.md
Name: mvm_addr_seq

Overview:
Parametrised successor to the single-lane matrix-vector address controller. Generates vector and matrix SRAM read addresses for a matrix-vector product and delays accumulator framing flags to match a configurable datapath latency. Over the previous generation it adds:
- a programmable matrix row stride;
- stall backpressure;
- a drain phase with a done pulse;
- configuration error detection.

Parameters:
VEC_ADDRW, 8, vector SRAM address width
MAT_ADDRW, 9, matrix SRAM address width
VEC_SIZEW, VEC_ADDRW+1, width of word-count field
MAT_SIZEW, MAT_ADDRW+1, width of row-count and stride fields
PIPE_LAT, 7, cycles from ovalid to the matching accum_valid (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  launch request; sampled only in IDLE
vec_start_addr  in  VEC_ADDRW  first vector word address
vec_num_words  in  VEC_SIZEW  words per row (N)
mat_start_addr  in  MAT_ADDRW  first matrix word address
mat_num_rows  in  MAT_SIZEW  rows per output lane (R)
mat_row_stride  in  MAT_SIZEW  address step between row bases (S)
stall  in  1  downstream backpressure; freezes issue
vec_raddr  out  VEC_ADDRW  registered vector read address
mat_raddr  out  MAT_ADDRW  registered matrix read address
ovalid  out  1  read addresses valid this cycle
accum_valid  out  1  ovalid delayed by PIPE_LAT
accum_first  out  1  first word of a row, aligned with accum_valid
accum_last  out  1  last word of a row, aligned with accum_valid
busy  out  1  high from the cycle after an accepted start through the done cycle
done  out  1  one-cycle pulse at completion
cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset: state=IDLE. All outputs 0. Counters, config registers and the delay line cleared.
- States: IDLE, COMPUTE, DRAIN.
- IDLE + start:
  - N==0 or R==0: pulse cfg_err next cycle and stay IDLE.
  - Otherwise latch all config, set word_cnt=0, row_cnt=0, row_base=mat_start_addr, and go to COMPUTE.
  - start is ignored outside IDLE.
- COMPUTE, per cycle with stall=0 ("issue"):
  - Register vec_raddr = vec_start + word_cnt and mat_raddr = row_base + word_cnt, both truncated mod 2^width.
  - ovalid=1 on the next cycle.
  - first flag = (word_cnt==0); last flag = (word_cnt==N-1).
  - On word_cnt==N-1: word_cnt=0, row_cnt++, row_base += S (incremental add, no multiplier, wraps mod 2^MAT_ADDRW).
  - Otherwise word_cnt++.
  - Issue with word_cnt==N-1 and row_cnt==R-1 is the final issue; next state is DRAIN.
- COMPUTE with stall=1: no issue, counters hold, ovalid=0 next cycle. Address outputs hold their last values.
- Delay line: {valid, first, last} shift register of depth PIPE_LAT. It advances every cycle regardless of stall; a non-issue cycle inserts valid=0. accum_* appear exactly PIPE_LAT cycles after the matching ovalid. accum_first/accum_last are only meaningful when accum_valid=1 and are 0 otherwise.
- DRAIN: counts PIPE_LAT cycles after the final ovalid, ignoring stall. done pulses in the same cycle as the final accum_valid; next state is IDLE.
- busy deasserts the cycle after done. A start in that IDLE cycle is accepted (back-to-back).
- Total cycles start->done with no stall: N*R + PIPE_LAT + 1.
- N==1: first and last are both high on every issue.
- S < N (overlapping rows) and S==0 are legal; no check is made.
- rst asserted mid-COMPUTE or mid-DRAIN: on the next edge everything returns to reset values, the delay line is flushed, and no done pulse is produced.

Test Plan:
- N=4, R=3, S=4, vec_start=0x10, mat_start=0x20, no stall: vec_raddr cycles 0x10..0x13 three times; mat_raddr runs 0x20..0x2B; 12 ovalid; accum_first on words 0,4,8 and accum_last on 3,7,11, each 7 cycles after its ovalid; done 20 cycles after start.
- Same config, stall high for 3 cycles after the 5th issue: addresses hold; ovalid has a 3-cycle gap mirrored in accum_valid 7 cycles later; done arrives 3 cycles later than unstalled.
- N=2, R=2, S=8, mat_start=0x1FC (MAT_ADDRW=9): mat_raddr 0x1FC, 0x1FD, 0x004, 0x005 (wrap).
- start with N=0, then with R=0: cfg_err pulses each time; busy, ovalid and done stay 0.
- N=1, R=5: five issues, each with first=last=1; then back-to-back start in the cycle after done is accepted.
- rst asserted at the 3rd issue of an N=4, R=2 run: all outputs 0 next cycle; no accum_valid or done appears afterwards.
